request_cnt: RTL

- Initiator side of the count-reply UART exchange.
- On activate, transmits one count byte N, then receives and checks the reply stream 0,1,…,N (N+1 bytes).
- Reports pass/fail, mismatch count and timeout to the command controller; used as an on-board loopback/link self-test.
- Sits between the command controller and the shared UART TX/RX cores.

---
 rtl/uart_cmd_pkg.sv | 20 ++
 rtl/rise_det.sv | 18 +
 rtl/request_cnt.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART count-reply command blocks (initiator and responder).
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TX,
    ST_SEND,
    ST_RECV,
    ST_DONE
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;
  localparam int DEFAULT_TO_W           = 20;

  // Error counters stick at all-ones rather than wrapping back to a "clean" value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector; a level held high produces a single strobe.
module rise_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) din_q <= 1'b0;
    else        din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/request_cnt.sv
// Count-reply initiator: sends N, then checks that the reply stream is 0,1,...,N.
module request_cnt
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TO_W           = DEFAULT_TO_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       activate,
  input  logic [7:0] req_count,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [7:0] err_count,
  output logic [8:0] rx_count,
  input  logic       tx_active,
  input  logic       tx_done,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic       tx_start
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  state_t          state, state_next;
  logic            rx_evt;
  logic [7:0]      expected_q;
  logic [8:0]      total_q;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_q;
  logic [TO_W-1:0] to_inc;
  logic            to_hit;
  logic [8:0]      rx_inc;
  logic            last_byte;
  logic            tx_done_unused;

  assign tx_done_unused = tx_done;

  rise_det u_rx_rise (
    .clk   (clk),
    .reset (reset),
    .din   (rx_ready),
    .rise  (rx_evt)
  );

  assign to_inc    = to_cnt + TO_W'(1);
  assign to_hit    = (to_inc == TO_LIMIT);
  assign rx_inc    = rx_count + 9'd1;
  assign last_byte = (rx_inc == total_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Dropping activate always wins; an rx strobe beats a coincident timeout in RECV.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (activate) state_next = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (!activate)       state_next = ST_IDLE;
        else if (!tx_active) state_next = ST_SEND;
        else if (to_hit)     state_next = ST_DONE;
      end
      ST_SEND:    state_next = activate ? ST_RECV : ST_IDLE;
      ST_RECV: begin
        if (!activate)   state_next = ST_IDLE;
        else if (rx_evt) begin
          if (last_byte) state_next = ST_DONE;
        end
        else if (to_hit) state_next = ST_DONE;
      end
      ST_DONE:    if (!activate) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Any path back to IDLE wipes the status so IDLE always presents reset values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data    <= '0;
      err_count  <= '0;
      rx_count   <= '0;
      expected_q <= '0;
      total_q    <= '0;
      to_cnt     <= '0;
      timeout_q  <= 1'b0;
    end else if (state_next == ST_IDLE) begin
      tx_data    <= '0;
      err_count  <= '0;
      rx_count   <= '0;
      expected_q <= '0;
      total_q    <= '0;
      to_cnt     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_data    <= req_count;
          expected_q <= '0;
          total_q    <= {1'b0, req_count} + 9'd1;
          to_cnt     <= '0;
          timeout_q  <= 1'b0;
        end
        ST_WAIT_TX: begin
          if (tx_active) begin
            if (to_hit) timeout_q <= 1'b1;
            else        to_cnt    <= to_inc;
          end
        end
        ST_SEND: to_cnt <= '0;
        ST_RECV: begin
          if (rx_evt) begin
            if (rx_data != expected_q) err_count <= sat_inc8(err_count);
            rx_count   <= rx_inc;
            expected_q <= expected_q + 8'd1;
            to_cnt     <= '0;
          end else if (to_hit) begin
            timeout_q <= 1'b1;
          end else begin
            to_cnt <= to_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done     = (state == ST_DONE);
    pass     = done && (err_count == 8'd0) && !timeout_q && (rx_count == total_q);
    timeout  = timeout_q;
    tx_start = (state == ST_SEND);
  end

endmodule
